// File: rtl/spec_adder_pkg.sv
// Shared types and defaults for the speculative variable-latency adder.
// Contents: FSM state enum, default WIDTH/BLK/CNT_W, configuration legality check.
package spec_adder_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_BLK   = 4;
  localparam int unsigned DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    FIX  = 2'd2,
    OUT  = 2'd3
  } state_e;

  // WIDTH must split evenly into blocks of at least two bits.
  function automatic bit cfg_ok(input int unsigned width, input int unsigned blk);
    return (blk >= 2) && (width >= blk) && ((width % blk) == 0);
  endfunction

endpackage

// File: rtl/spec_cla_block.sv
// BLK-bit carry-lookahead block.
// Ports: a, b (operand slices), ci (carry-in) -> s (sum slice), co (carry-out),
//        p (group propagate), g (group generate). p/g do not depend on ci.
module spec_cla_block
  import spec_adder_pkg::*;
#(
  parameter int unsigned BLK = DEF_BLK
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           ci,
  output logic [BLK-1:0] s,
  output logic           co,
  output logic           p,
  output logic           g
);

  logic [BLK-1:0] prop;
  logic [BLK-1:0] gen;

  // Bit carries and group generate folded from the bit-level P/G terms.
  always_comb begin
    logic carry;
    logic gg;
    prop  = a ^ b;
    gen   = a & b;
    s     = '0;
    carry = ci;
    gg    = 1'b0;
    for (int unsigned i = 0; i < BLK; i++) begin
      s[i]  = prop[i] ^ carry;
      carry = gen[i] | (prop[i] & carry);
      gg    = gen[i] | (prop[i] & gg);
    end
    p  = &prop;
    g  = gg;
    co = gg | (&prop & ci);
  end

endmodule

// File: rtl/spec_var_latency_adder.sv
// Variable-latency speculative adder with valid/ready handshake.
// Blocks above block 0 start from a predicted carry (generate of the MSB below);
// a P/G chain yields the true block carries and flags mispredictions.
// Optional macro ERROR_RECOVERY_EN: adds the FIX state and exact-sum path so
// mispredicted results cost one extra cycle but are delivered exact.
// Ports: clk, rst (sync, active-high); in_valid/in_ready, a, b, cin (operands);
//        out_valid/out_ready, sum, cout, spec_err, exact (result);
//        err_cnt (saturating misprediction count).
module spec_var_latency_adder
  import spec_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned BLK   = DEF_BLK,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             spec_err,
  output logic             exact,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned NB = WIDTH / BLK;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (!cfg_ok(WIDTH, BLK)) begin : g_cfg_check
    $error("spec_var_latency_adder: WIDTH must be a multiple of BLK and BLK >= 2");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             spec_err_q, spec_err_d;
  logic             exact_q, exact_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [NB-1:0]    pc;
  logic [NB-1:0]    blk_p;
  logic [NB-1:0]    blk_g;
  logic [NB-1:0]    blk_co;
  logic [NB:0]      ac;
  logic [WIDTH-1:0] spec_sum;
  logic             spec_cout;
  logic             err_c;
  logic             in_ready_c;
  logic             accept_c;

  // Predicted block carries: exact cin for block 0, MSB generate below otherwise.
  always_comb begin
    pc    = '0;
    pc[0] = cin_q;
    for (int unsigned k = 1; k < NB; k++) begin
      pc[k] = a_q[k*BLK-1] & b_q[k*BLK-1];
    end
  end

  for (genvar k = 0; k < NB; k++) begin : g_blk
    spec_cla_block #(.BLK(BLK)) u_cla (
      .a  (a_q[k*BLK +: BLK]),
      .b  (b_q[k*BLK +: BLK]),
      .ci (pc[k]),
      .s  (spec_sum[k*BLK +: BLK]),
      .co (blk_co[k]),
      .p  (blk_p[k]),
      .g  (blk_g[k])
    );
  end

  assign spec_cout = blk_co[NB-1];

  // True block carries from the group P/G chain; prediction can only miss a carry.
  always_comb begin
    logic carry;
    ac    = '0;
    err_c = 1'b0;
    carry = cin_q;
    ac[0] = carry;
    for (int unsigned k = 0; k < NB; k++) begin
      carry   = blk_g[k] | (blk_p[k] & carry);
      ac[k+1] = carry;
    end
    for (int unsigned k = 1; k < NB; k++) begin
      err_c = err_c | (ac[k] & ~pc[k]);
    end
  end

  // Lower-block carry-outs are superseded by the P/G chain.
  logic unused_sink;

`ifdef ERROR_RECOVERY_EN
  logic [WIDTH-1:0] exact_sum;
  logic             exact_cout;

  // Exact sum: each block re-evaluated from its true carry-in.
  always_comb begin
    logic        carry;
    int unsigned j;
    exact_sum = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      carry = ac[k];
      for (int unsigned i = 0; i < BLK; i++) begin
        j            = k * BLK + i;
        exact_sum[j] = a_q[j] ^ b_q[j] ^ carry;
        carry        = (a_q[j] & b_q[j]) | ((a_q[j] ^ b_q[j]) & carry);
      end
    end
  end

  assign exact_cout  = ac[NB];
  assign unused_sink = ^blk_co;
`else
  assign unused_sink = ^{blk_co, ac[NB]};
`endif

  assign in_ready_c = (state_q == IDLE) | ((state_q == OUT) & out_ready);
  assign accept_c   = in_valid & in_ready_c;

  // Next-state, operand capture and result loading.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    spec_err_d  = spec_err_q;
    exact_d     = exact_q;
    out_valid_d = out_valid_q;
    err_cnt_d   = err_cnt_q;

    if (accept_c) begin
      a_d   = a;
      b_d   = b;
      cin_d = cin;
    end

    case (state_q)
      IDLE: begin
        if (accept_c) state_d = EVAL;
      end
      EVAL: begin
        if (err_c && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + CNT_W'(1);
`ifdef ERROR_RECOVERY_EN
        if (err_c) begin
          state_d = FIX;
        end else begin
`else
        begin
`endif
          sum_d       = spec_sum;
          cout_d      = spec_cout;
          spec_err_d  = err_c;
          exact_d     = ~err_c;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end
      end
      FIX: begin
`ifdef ERROR_RECOVERY_EN
        sum_d       = exact_sum;
        cout_d      = exact_cout;
        spec_err_d  = 1'b1;
        exact_d     = 1'b1;
        out_valid_d = 1'b1;
        state_d     = OUT;
`else
        state_d     = IDLE;
`endif
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = in_valid ? EVAL : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      spec_err_q  <= 1'b0;
      exact_q     <= 1'b0;
      out_valid_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      spec_err_q  <= spec_err_d;
      exact_q     <= exact_d;
      out_valid_q <= out_valid_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign spec_err  = spec_err_q;
  assign exact     = exact_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_spec_var_latency_adder.sv
// Directed bench for spec_var_latency_adder (WIDTH=16, BLK=4, CNT_W=4).
// Expectations follow ERROR_RECOVERY_EN when the bench is built with it.
module tb_spec_var_latency_adder;

`ifdef ERROR_RECOVERY_EN
  localparam bit REC = 1'b1;
`else
  localparam bit REC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        spec_err;
  logic        exact;
  logic [3:0]  err_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  spec_var_latency_adder #(.WIDTH(16), .BLK(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .spec_err  (spec_err),
    .exact     (exact),
    .err_cnt   (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Count cycles from the accept cycle until out_valid is seen (bounded).
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
  endtask

  // One transaction from IDLE; xs/xc exact result, ss/sc speculative result.
  task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic tc, input logic [15:0] xs, input logic xc,
                       input logic [15:0] ss, input logic sc, input logic terr);
    int lat;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    if (terr && exp_cnt < 15) exp_cnt++;
    chk({tag, "_latency"}, 32'(lat), (terr && REC) ? 32'd3 : 32'd2);
    chk({tag, "_sum"}, 32'(sum), 32'((REC || !terr) ? xs : ss));
    chk({tag, "_cout"}, 32'(cout), 32'((REC || !terr) ? xc : sc));
    chk({tag, "_spec_err"}, 32'(spec_err), 32'(terr));
    chk({tag, "_exact"}, 32'(exact), REC ? 32'd1 : 32'(!terr));
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_cnt));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_spec_err", 32'(spec_err), 32'd0);
    chk("rst_exact", 32'(exact), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);

    //     tag      a        b        cin   exact sum/cout   spec sum/cout    err
    do_op("v1_3",   16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 16'h0003, 1'b0, 1'b0);
    do_op("v2_pc",  16'h0008, 16'h0008, 1'b0, 16'h0010, 1'b0, 16'h0010, 1'b0, 1'b0);
    do_op("v3_miss",16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 16'h0000, 1'b0, 1'b1);
    do_op("v4_wrap",16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 16'hFFF0, 1'b0, 1'b1);
    do_op("v5_cin", 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 16'h00F0, 1'b0, 1'b1);
    do_op("v6_top", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    do_op("v7_nocy",16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 16'h5555, 1'b0, 1'b0);

    // Back-pressure: result held for 5 cycles, then hand-over plus accept together.
    a = 16'h0001; b = 16'h0002; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    chk("bp_latency", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_sum", 32'(sum), 32'h0003);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    a = 16'h1234; b = 16'h4321; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("bp_in_ready_comb", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    wait_out(lat);
    chk("b2b_latency", 32'(lat), 32'd2);
    chk("b2b_sum", 32'(sum), 32'h5555);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);

    // Reset two cycles after accepting a mispredicting op (FIX when recovery is in).
    a = 16'h000F; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    chk("mrst_err_cnt", 32'(err_cnt), 32'd0);
    chk("mrst_sum", 32'(sum), 32'd0);
    chk("mrst_exact", 32'(exact), 32'd0);

    // Saturation of the 4-bit error counter.
    for (int i = 0; i < 20; i++) begin
      do_op("sat", 16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 16'h0000, 1'b0, 1'b1);
    end
    chk("sat_final", 32'(err_cnt), 32'd15);

    do_op("post_sat", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 16'h0003, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
